ffe_error_gen: RTL
==================

Name: ffe_error_gen

Overview:
- Time-multiplexed feed-forward equalizer datapath: the read side of the LMS coefficient update.
- Holds the x[k] delay line and reads the NTAPS coefficients the tap-update blocks write.
- Computes y = sum w[k]·x[n-k] with one MAC per cycle, slices y, and forms error = y - d.
- Presents error plus the aligned x[k] snapshot to the tap-update blocks, which compute w - mu·e·x.

Parameters:
NTAPS, 8, number of taps (>=2)
NB_I, 18, x and y width
NBF_I, 15, x and y fractional bits
NB, 8, coefficient width
NBF, 7, coefficient fractional bits
NB_ERROR, 19, error width (NB_I+1)
NBF_ERROR, 15, error fractional bits (= NBF_I)

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
i_valid  in  1  new sample offered
i_x  in  NB_I  new sample, signed Q(NB_I,NBF_I)
o_ready  out  1  block can accept a sample
i_w_flat  in  NTAPS*NB  coefficients, tap k at bits [k*NB +: NB], signed
i_train  in  1  1 = use i_ref as decision
i_ref  in  NB_I  training symbol, signed
o_y  out  NB_I  saturated filter output
o_error  out  NB_ERROR  y - d, signed
o_xk_flat  out  NTAPS*NB_I  delay-line snapshot aligned with o_error, x[n-k] at [k*NB_I +: NB_I]
o_valid  out  1  one-cycle pulse: o_y, o_error, o_xk_flat updated

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset values:
  - Delay line, coefficient snapshot, accumulator, tap counter, o_y, o_error, o_xk_flat: all 0.
  - o_valid = 0; state = IDLE, so o_ready = 1.
- FSM states: IDLE, MAC, OUT. o_ready = 1 only in IDLE.
- IDLE:
  - Acceptance occurs on i_valid & o_ready at a clock edge.
  - The delay line shifts: x[0] <= i_x, x[k] <= x[k-1], oldest sample dropped.
  - i_w_flat, i_train and i_ref are captured into snapshot registers.
  - acc <= 0, cnt <= 0, state -> MAC.
- MAC:
  - Each edge: acc <= acc + x[cnt]*wsnap[cnt]; cnt++.
  - After the edge with cnt = NTAPS-1, state -> OUT. This takes exactly NTAPS edges.
  - i_valid and i_w_flat changes are ignored during MAC.
- OUT: one edge; registers outputs, pulses o_valid; state -> IDLE.
- Latency: o_valid is high in the cycle starting NTAPS+1 edges after the acceptance edge.
- o_ready is already 1 in the o_valid cycle, so a new acceptance may coincide with o_valid.
- Throughput: 1 sample per NTAPS+2 cycles.
- Arithmetic widths:
  - Product: NB_I+NB bits, NBF_I+NBF fractional bits.
  - acc: NB_I+NB+clog2(NTAPS) bits, full precision, no overflow possible.
- y formation:
  - Arithmetic-shift acc right by NBF (truncation toward -inf).
  - Saturate to NB_I: above max -> 2^(NB_I-1)-1; below min -> -2^(NB_I-1).
- Decision d:
  - Training (i_train snapshot = 1): d = i_ref snapshot.
  - Otherwise PAM2 slicer: d = +2^NBF_I (+1.0) if y >= 0, else -2^NBF_I.
- error = sext(y) - sext(d) in NB_ERROR bits. This is exact; no saturation is needed.
- o_xk_flat = the delay line contents used for this output, i.e. the state after the shift at acceptance.
- Outputs hold their value between o_valid pulses.
- Reset asserted mid-MAC or mid-OUT: immediate abort to reset values; no o_valid is produced.

Test Plan:
- Reset, then idle 20 cycles -> o_ready=1, o_valid=0, o_y=0, o_error=0, o_xk_flat=0.
- Impulse: w0=0x40 (0.5), others 0; accept x=16384 (0.5) -> o_valid exactly 9 cycles later; o_y=8192, d=+32768, o_error=-24576; x[0]=16384 in o_xk_flat.
- Delay alignment: w3=0x7F, others 0; samples 1000, 2000, 3000, 4000 -> outputs 1-3: o_y=0, o_error=-32768 (slicer +1.0); output 4: o_y=992 (127000>>7), o_error=-31776; o_xk_flat x[3]=1000, x[0]=4000.
- Positive saturation: all w=0x7F, 8 samples of x=131071 -> 8th output o_y=131071, o_error=98303.
- Negative saturation: all w=0x80 (-1.0), 8 samples of x=131071 -> o_y=-131072, o_error=-98304.
- Training and robustness:
  - i_train=1, i_ref=-32768, impulse case above -> o_error=40960.
  - i_valid held high throughout -> exactly one acceptance per NTAPS+2 cycles.
  - i_w_flat changed during MAC -> result unchanged.
  - i_rst_n pulsed low mid-MAC -> no o_valid; delay line cleared.

Source files
------------

// File: rtl/ffe_error_gen.sv
// Time-multiplexed FFE datapath: one MAC per cycle over the x[k] delay line,
// then saturation, slicing and error formation for the LMS tap-update blocks.
module ffe_error_gen #(
    parameter int NTAPS     = 8,
    parameter int NB_I      = 18,
    parameter int NBF_I     = 15,
    parameter int NB        = 8,
    parameter int NBF       = 7,
    parameter int NB_ERROR  = 19,
    parameter int NBF_ERROR = 15
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_valid,
    input  logic [NB_I-1:0]         i_x,
    output logic                    o_ready,
    input  logic [NTAPS*NB-1:0]     i_w_flat,
    input  logic                    i_train,
    input  logic [NB_I-1:0]         i_ref,
    output logic [NB_I-1:0]         o_y,
    output logic [NB_ERROR-1:0]     o_error,
    output logic [NTAPS*NB_I-1:0]   o_xk_flat,
    output logic                    o_valid
);

    localparam int CNT_W     = (NTAPS > 1) ? $clog2(NTAPS) : 1;
    localparam int PROD_W    = NB_I + NB;
    localparam int ACC_W     = NB_I + NB + $clog2(NTAPS);
    localparam int EXT_W     = NB_ERROR - NB_I;
    localparam int ERR_SHIFT = NBF_ERROR - NBF_I;

    localparam logic [CNT_W-1:0]        CNT_LAST = CNT_W'(NTAPS - 1);
    localparam logic signed [ACC_W-1:0] Y_MAX    = ACC_W'((longint'(1) <<< (NB_I - 1)) - 1);
    localparam logic signed [ACC_W-1:0] Y_MIN    = ACC_W'(-(longint'(1) <<< (NB_I - 1)));
    localparam logic signed [NB_I-1:0]  D_POS    = NB_I'(longint'(1) <<< NBF_I);
    localparam logic signed [NB_I-1:0]  D_NEG    = NB_I'(-(longint'(1) <<< NBF_I));

    typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

    state_t state_reg, state_next;

    logic signed [NB_I-1:0]  x_reg [NTAPS];
    logic signed [NB-1:0]    w_reg [NTAPS];
    logic signed [NB-1:0]    w_in  [NTAPS];
    logic [NTAPS*NB_I-1:0]   x_flat;

    logic                    train_reg;
    logic signed [NB_I-1:0]  ref_reg;
    logic signed [ACC_W-1:0] acc_reg;
    logic [CNT_W-1:0]        cnt_reg;

    logic [NB_I-1:0]         y_reg;
    logic [NB_ERROR-1:0]     err_reg;
    logic [NTAPS*NB_I-1:0]   xk_reg;
    logic                    valid_reg;

    logic                    accept;
    logic signed [PROD_W-1:0]   prod;
    logic signed [ACC_W-1:0]    acc_shift;
    logic signed [NB_I-1:0]     y_sat;
    logic signed [NB_I-1:0]     d_sel;
    logic signed [NB_ERROR-1:0] y_ext;
    logic signed [NB_ERROR-1:0] d_ext;
    logic signed [NB_ERROR-1:0] err_next;

    genvar gi;
    generate
        for (gi = 0; gi < NTAPS; gi++) begin : g_tap
            assign w_in[gi]                   = i_w_flat[gi*NB +: NB];
            assign x_flat[gi*NB_I +: NB_I]    = x_reg[gi];
        end
    endgenerate

    assign accept  = i_valid && (state_reg == IDLE);
    assign o_ready = (state_reg == IDLE);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state_reg <= IDLE;
        else          state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = MAC;
            MAC:     if (cnt_reg == CNT_LAST) state_next = OUT;
            OUT:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Both operands are signed, so this is a full-precision signed product.
    assign prod = x_reg[cnt_reg] * w_reg[cnt_reg];

    // Drop the coefficient fraction (floor), then clamp into the NB_I range.
    always_comb begin
        acc_shift = acc_reg >>> NBF;
        if (acc_shift > Y_MAX)      y_sat = {1'b0, {(NB_I-1){1'b1}}};
        else if (acc_shift < Y_MIN) y_sat = {1'b1, {(NB_I-1){1'b0}}};
        else                        y_sat = acc_shift[NB_I-1:0];
        if (train_reg)              d_sel = ref_reg;
        else if (y_sat[NB_I-1])     d_sel = D_NEG;
        else                        d_sel = D_POS;
        y_ext    = {{EXT_W{y_sat[NB_I-1]}}, y_sat};
        d_ext    = {{EXT_W{d_sel[NB_I-1]}}, d_sel};
        err_next = (y_ext - d_ext) <<< ERR_SHIFT;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < NTAPS; k++) begin
                x_reg[k] <= '0;
                w_reg[k] <= '0;
            end
            train_reg <= 1'b0;
            ref_reg   <= '0;
            acc_reg   <= '0;
            cnt_reg   <= '0;
            y_reg     <= '0;
            err_reg   <= '0;
            xk_reg    <= '0;
            valid_reg <= 1'b0;
        end else begin
            valid_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        x_reg[0] <= i_x;
                        for (int k = 1; k < NTAPS; k++) x_reg[k] <= x_reg[k-1];
                        for (int k = 0; k < NTAPS; k++) w_reg[k] <= w_in[k];
                        train_reg <= i_train;
                        ref_reg   <= i_ref;
                        acc_reg   <= '0;
                        cnt_reg   <= '0;
                    end
                end
                MAC: begin
                    acc_reg <= acc_reg + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
                    cnt_reg <= cnt_reg + CNT_W'(1);
                end
                OUT: begin
                    y_reg     <= y_sat;
                    err_reg   <= err_next;
                    xk_reg    <= x_flat;
                    valid_reg <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign o_y       = y_reg;
    assign o_error   = err_reg;
    assign o_xk_flat = xk_reg;
    assign o_valid   = valid_reg;

endmodule
